// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared NoC flit geometry, field positions and flit decode helper
package noc_pkg;

  localparam int FLIT_W    = 16;
  localparam int ID_W      = 2;
  localparam int SEQ_W     = 11;
  localparam int NUM_NODES = 4;

  localparam int VLD_BIT  = 0;
  localparam int DEST_LSB = 1;
  localparam int SRC_LSB  = 3;
  localparam int SEQ_LSB  = 5;

  typedef struct packed {
    logic [SEQ_W-1:0] seq;
    logic [ID_W-1:0]  src;
    logic [ID_W-1:0]  dest;
    logic             vld;
  } flit_t;

  function automatic flit_t unpack_flit(input logic [FLIT_W-1:0] raw);
    flit_t f;
    f.vld  = raw[VLD_BIT];
    f.dest = raw[DEST_LSB +: ID_W];
    f.src  = raw[SRC_LSB +: ID_W];
    f.seq  = raw[SEQ_LSB +: SEQ_W];
    return f;
  endfunction

endpackage

// File: rtl/noc_sink_if.sv
// rtl/noc_sink_if.sv - output-FIFO drain handshake between a NoC port FIFO and its sink
interface noc_sink_if;
  import noc_pkg::*;

  logic              enable;
  logic              empty;
  logic              almost_empty;
  logic [FLIT_W-1:0] data_in;
  logic              read;

  modport master (output enable, output empty, output almost_empty, output data_in, input read);
  modport slave  (input enable, input empty, input almost_empty, input data_in, output read);

endinterface

// File: rtl/noc_seq_checker.sv
// rtl/noc_seq_checker.sv - per-source expected-sequence tracker; flags gaps and resyncs
module noc_seq_checker
  import noc_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             chk_en,
  input  logic [ID_W-1:0]  src,
  input  logic [SEQ_W-1:0] seq,
  output logic             seq_err
);

  logic [NUM_NODES-1:0] seen_q;
  logic [SEQ_W-1:0]     exp_q [NUM_NODES];

  // First flit from a source is accepted unconditionally; later ones must follow mod 2^SEQ_W.
  assign seq_err = chk_en & seen_q[src] & (seq != exp_q[src]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seen_q <= '0;
      for (int i = 0; i < NUM_NODES; i++) exp_q[i] <= '0;
    end else if (chk_en) begin
      seen_q[src] <= 1'b1;
      exp_q[src]  <= seq + 1'b1;
    end
  end

endmodule

// File: rtl/noc_sink.sv
// rtl/noc_sink.sv - NoC receive endpoint: drains the port FIFO, decodes and checks flits
module noc_sink
  import noc_pkg::*;
#(
  parameter logic [ID_W-1:0] MY_ID = '0,
  parameter int              CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  noc_sink_if.slave        fifo,
  output logic             rx_valid,
  output logic [ID_W-1:0]  rx_src,
  output logic [SEQ_W-1:0] rx_seq,
  output logic [CNT_W-1:0] pkt_count,
  output logic [CNT_W-1:0] err_dest,
  output logic [CNT_W-1:0] err_seq,
  output logic [CNT_W-1:0] err_vld
);

  logic       read_q, read_d;
  logic       rd_q;
  logic       cap_q;
  flit_t      flit_q;
  logic       chk_en, seq_err;
  logic [CNT_W-1:0] pkt_q, pkt_d, edest_q, edest_d, eseq_q, eseq_d, evld_q, evld_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // While a read is already outstanding the FIFO has not yet popped, so one remaining
  // entry (almost_empty) is the last one we may take.
  assign read_d = fifo.enable & ((read_q & ~fifo.almost_empty) | (~read_q & ~fifo.empty));
  assign fifo.read = read_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_q <= 1'b0;
      rd_q   <= 1'b0;
      cap_q  <= 1'b0;
      flit_q <= '0;
    end else begin
      read_q <= read_d;
      rd_q   <= read_q;
      cap_q  <= rd_q;
      if (rd_q) flit_q <= unpack_flit(fifo.data_in);
    end
  end

  assign chk_en = cap_q & flit_q.vld;

  noc_seq_checker u_seq_checker (
    .clk     (clk),
    .reset   (reset),
    .chk_en  (chk_en),
    .src     (flit_q.src),
    .seq     (flit_q.seq),
    .seq_err (seq_err)
  );

  always_comb begin
    pkt_d   = pkt_q;
    edest_d = edest_q;
    eseq_d  = eseq_q;
    evld_d  = evld_q;
    if (cap_q) begin
      if (!flit_q.vld) begin
        evld_d = sat_inc(evld_q);
      end else begin
        pkt_d = sat_inc(pkt_q);
        if (flit_q.dest != MY_ID) edest_d = sat_inc(edest_q);
        if (seq_err)              eseq_d  = sat_inc(eseq_q);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt_q   <= '0;
      edest_q <= '0;
      eseq_q  <= '0;
      evld_q  <= '0;
    end else begin
      pkt_q   <= pkt_d;
      edest_q <= edest_d;
      eseq_q  <= eseq_d;
      evld_q  <= evld_d;
    end
  end

  assign rx_valid  = cap_q;
  assign rx_src    = flit_q.src;
  assign rx_seq    = flit_q.seq;
  assign pkt_count = pkt_q;
  assign err_dest  = edest_q;
  assign err_seq   = eseq_q;
  assign err_vld   = evld_q;

endmodule
